text_ram_arbiter: RTL and testbench
===================================

Name: text_ram_arbiter

Overview:
Arbitrates a single-port synchronous character RAM (80x30 text cells) between the VGA display fetch path and two writer requesters, such as a button-driven editor and a host port. Display reads have absolute priority and are never stalled. Writes are served round-robin in slots the display does not use. A built-in clear engine fills the screen with a fill character on request. The block sits between the VGA timing/display logic and the text RAM, in the clk100 domain.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 8, character/attribute word width
CELLS, 2400, number of valid cells (80x30); addresses >= CELLS are out of range
FILL_CHAR, 8'h20, value written by the clear engine

Ports:
clk100  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
disp_req  in  1  display read request, single-cycle, any cycle
disp_addr  in  ADDR_W  display read address
disp_data  out  DATA_W  read data, registered
disp_valid  out  1  disp_data valid, 1 cycle
wr0_req  in  1  writer 0 request, level
wr0_addr  in  ADDR_W  writer 0 address
wr0_data  in  DATA_W  writer 0 data
wr0_ack  out  1  writer 0 write performed, 1-cycle pulse
wr1_req, wr1_addr, wr1_data, wr1_ack  same as writer 0
clear_start  in  1  start screen clear, pulse
busy  out  1  clear in progress
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle latency

Behaviour:
- Clock is clk100; reset is synchronous and active-high. All outputs reset to 0. The round-robin pointer resets to writer 0. The state resets to IDLE.
- RAM port outputs are combinational from the current-cycle grant. disp_data/disp_valid are registered: ram_rdata is captured with disp_valid=1 exactly 1 cycle after disp_req. No other path asserts disp_valid.
- Slot priority each cycle: disp_req, then the clear engine (state CLEAR), then writers.
- When disp_req=1: ram_en=1, ram_we=0, ram_addr=disp_addr. No write and no ack occur in that cycle.
- Writer handshake:
  - The writer holds req/addr/data stable until ack.
  - ack is a 1-cycle pulse in the cycle ram_we=1 for that writer.
  - The writer must drop req in the cycle after ack. If req is still high, it counts as a new request.
- Round-robin between writers: if both request in a free slot, grant the writer not granted last. The pointer updates only on a grant.
- Out-of-range writer address (>= CELLS): ack is still pulsed in a free slot, but ram_en=0 and ram_we=0. No RAM access occurs. This still counts as a grant for round-robin.
- Display addresses pass through unchecked.
- State machine IDLE / CLEAR:
  - IDLE -> CLEAR on clear_start=1. The clear counter is set to 0 and busy=1 from the next cycle.
  - In CLEAR, each cycle without disp_req writes FILL_CHAR at the counter address (ram_we=1), then increments the counter. Writers receive no ack while in CLEAR.
  - After writing address CELLS-1: CLEAR -> IDLE and busy=0 the next cycle. The counter does not wrap.
  - clear_start while in CLEAR is ignored (no restart).
- Simultaneous clear_start and writer requests in IDLE: the writer may be served in that cycle. CLEAR begins the next cycle.
- Reset mid-clear aborts the clear, leaving the RAM partially filled. Reset with a pending ack or valid clears it; no pulse is emitted afterwards.
- Worst-case writer latency outside CLEAR: 2 free slots.

Optional Feature:
TEXTARB_STATS_EN
- Defined: adds output stall_cnt [15:0]. It increments by 1 in each cycle where any wrX_req=1 and no writer is acked. It saturates at 16'hFFFF and is cleared by reset.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package text_pkg holds: TEXT_COLS=80, TEXT_ROWS=30, CELLS, ADDR_W, DATA_W, FILL_CHAR, and the arbiter state enum (IDLE, CLEAR).
- One sub-module is natural: text_rr_arb2. It is a 2-way round-robin arbiter with pointer, taking req[1:0] and enable, and producing a one-hot grant[1:0].

Test Plan:
- disp_req with addr 12'h005 (RAM holds 8'h41) -> ram_en=1, ram_we=0 that cycle; next cycle disp_valid=1, disp_data=8'h41.
- wr0 and wr1 both request continuously, no display traffic -> acks alternate wr0, wr1, wr0, ... starting with wr0 after reset. Each ack coincides with ram_we=1 and the correct addr/data.
- wr0_req held while disp_req=1 for 3 cycles -> no ack for 3 cycles; ack on cycle 4 with the write performed.
- clear_start with disp_req every 4th cycle -> busy for exactly 2400 + (skipped display slots) cycles. Every address 0..2399 is written 8'h20 once, and writers are not acked until busy=0.
- wr1 write to address 2400 -> wr1_ack=1, ram_en=0, RAM unchanged.
- reset asserted at clear counter 1000 -> next cycle busy=0, no further writes; addresses 0..999 hold 8'h20 and the rest are unchanged. With TEXTARB_STATS_EN, stall_cnt reads 0 after reset.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants and state type for the text RAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package text_pkg;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int CELLS     = TEXT_COLS * TEXT_ROWS;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;
    localparam logic [DATA_W-1:0] FILL_CHAR = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;
endpackage

// File: rtl/text_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the winner.
// Latency: grant is combinational in the request cycle; pointer updates on the next edge.
// Backpressure: en=0 withholds every grant and freezes the pointer.
module text_rr_arb2 (
    input  logic       clk100,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    // ptr_q names the requester that wins a tie (1 = requester 1)
    logic ptr_q, ptr_d;

    // Grant: single requester wins outright, ties go to the pointed requester
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // Pointer moves to the requester that did not win, only when a grant occurs
    always_comb begin
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register, requester 0 preferred after reset
    always_ff @(posedge clk100) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: display reads first, then clear engine, then two round-robin writers.
// Latency: RAM port is combinational from the grant; disp_data/disp_valid appear 1 cycle after disp_req.
// Backpressure: writers wait (req held) until ack; display is never stalled. Optional TEXTARB_STATS_EN adds stall_cnt.
module text_ram_arbiter
    import text_pkg::*;
(
    input  logic              clk100,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ack,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ack,
    input  logic              clear_start,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef TEXTARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CELLS - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              disp_valid_q, disp_valid_d;
    logic [1:0]        wr_grant;
    logic              wr_slot_free;
    logic [ADDR_W-1:0] wr_sel_addr;
    logic [DATA_W-1:0] wr_sel_data;

    // Writers only get slots the display and clear engine leave unused
    assign wr_slot_free = !reset && !disp_req && (state_q == IDLE);

    text_rr_arb2 u_rr (
        .clk100 (clk100),
        .reset  (reset),
        .en     (wr_slot_free),
        .req    ({wr1_req, wr0_req}),
        .grant  (wr_grant)
    );

    assign wr_sel_addr = wr_grant[1] ? wr1_addr : wr0_addr;
    assign wr_sel_data = wr_grant[1] ? wr1_data : wr0_data;

    // State and clear-counter registers
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    // Next state: start a clear from IDLE, advance the fill address on free slots
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        disp_valid_d = disp_req;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (!disp_req) begin
                    if (clr_cnt_q == LAST_A) begin
                        state_d = IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM port from this cycle's slot owner; out-of-range writes ack without touching RAM
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        wr0_ack   = 1'b0;
        wr1_ack   = 1'b0;
        busy      = (state_q == CLEAR);
        if (!reset) begin
            if (disp_req) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end else if (state_q == CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = FILL_CHAR;
            end else if (|wr_grant) begin
                wr0_ack   = wr_grant[0];
                wr1_ack   = wr_grant[1];
                ram_addr  = wr_sel_addr;
                ram_wdata = wr_sel_data;
                if (wr_sel_addr < CELLS_A) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end
            end
        end
    end

    // The RAM output register already holds the read word in the valid cycle
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q ? ram_rdata : '0;

`ifdef TEXTARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter register
    always_ff @(posedge clk100) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Count cycles where a writer waits without an ack, saturating
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((wr0_req || wr1_req) && !(|wr_grant) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_text_ram_arbiter.sv
// Self-checking bench for text_ram_arbiter: directed vectors plus a per-cycle slot-ownership model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_text_ram_arbiter;
    logic        clk100 = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        wr0_req, wr1_req;
    logic [11:0] wr0_addr, wr1_addr;
    logic [7:0]  wr0_data, wr1_data;
    logic        wr0_ack, wr1_ack;
    logic        clear_start;
    logic        busy;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk100 = ~clk100;

    text_ram_arbiter dut (
        .clk100      (clk100),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .wr0_req     (wr0_req),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr0_ack     (wr0_ack),
        .wr1_req     (wr1_req),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .wr1_ack     (wr1_ack),
        .clear_start (clear_start),
        .busy        (busy),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
`ifdef TEXTARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

`ifndef TEXTARB_STATS_EN
    assign stall_cnt = 16'h0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'(i * 3 + 1) | 8'h80;
        if (i == 5) v = 8'h41;
        return v;
    endfunction

    // Character RAM: 1-cycle read latency, write counting, bench-controlled preload
    logic [7:0] mem [0:4095];
    int         wcount [0:4095];
    logic       pre_go = 1'b0;
    always @(posedge clk100) begin
        if (pre_go) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i]    <= pat(i);
                wcount[i] <= 0;
            end
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]    <= ram_wdata;
                wcount[ram_addr] <= wcount[ram_addr] + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // Model: who owns the slot this cycle, from the priority rules alone
    bit         m_clear = 1'b0;
    int         m_idx   = 0;
    int         m_pref  = 0;
    bit         m_pend  = 1'b0;
    logic [7:0] m_pdata = 8'h0;
    int         m_stall = 0;
    always @(negedge clk100) begin : model
        bit         e_en, e_we, e_a0, e_a1;
        logic [11:0] e_addr;
        logic [7:0]  e_wd;
        int          w;
        e_en = 0; e_we = 0; e_a0 = 0; e_a1 = 0; e_addr = 0; e_wd = 0; w = -1;
        if (!reset) begin
            if (disp_req) begin
                e_en = 1; e_addr = disp_addr;
            end else if (m_clear) begin
                e_en = 1; e_we = 1; e_addr = 12'(m_idx); e_wd = 8'h20;
            end else begin
                if (wr0_req && wr1_req) w = m_pref;
                else if (wr0_req) w = 0;
                else if (wr1_req) w = 1;
                if (w >= 0) begin
                    e_a0 = (w == 0); e_a1 = (w == 1);
                    e_addr = (w == 1) ? wr1_addr : wr0_addr;
                    e_wd   = (w == 1) ? wr1_data : wr0_data;
                    if (int'(e_addr) < 2400) begin e_en = 1; e_we = 1; end
                end
            end
        end
        chk("m_ram_en", 32'(ram_en), 32'(e_en));
        chk("m_ram_we", 32'(ram_we), 32'(e_we));
        if (e_en) chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) chk("m_ram_wdata", 32'(ram_wdata), 32'(e_wd));
        chk("m_wr0_ack", 32'(wr0_ack), 32'(e_a0));
        chk("m_wr1_ack", 32'(wr1_ack), 32'(e_a1));
        chk("m_busy", 32'(busy), 32'(m_clear));
        chk("m_disp_valid", 32'(disp_valid), 32'(m_pend));
        if (m_pend) chk("m_disp_data", 32'(disp_data), 32'(m_pdata));
`ifdef TEXTARB_STATS_EN
        chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        // advance model to the next cycle
        if (reset) begin
            m_clear = 0; m_pref = 0; m_pend = 0; m_stall = 0;
        end else begin
            m_pend = disp_req;
            m_pdata = mem[disp_addr];
            if ((wr0_req || wr1_req) && w < 0 && m_stall < 65535) m_stall++;
            if (w >= 0) m_pref = 1 - w;
            if (!m_clear) begin
                if (clear_start) begin m_clear = 1; m_idx = 0; end
            end else if (!disp_req) begin
                if (m_idx == 2399) m_clear = 0;
                else m_idx++;
            end
        end
    end

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, busy_cycles, skipped, wr1_busy_acks;
        bit done;
        reset = 1; disp_req = 0; disp_addr = 0; clear_start = 0;
        wr0_req = 0; wr0_addr = 0; wr0_data = 0;
        wr1_req = 0; wr1_addr = 0; wr1_data = 0;
        pre_go = 1;
        @(negedge clk100);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_acks", 32'({wr1_ack, wr0_ack}), 0);
        step();
        pre_go = 0; reset = 0;
        step();

        // display read of address 5 (holds 8'h41)
        disp_req = 1; disp_addr = 12'h005;
        @(negedge clk100);
        chk("rd_ram_en", 32'(ram_en), 1);
        chk("rd_ram_we", 32'(ram_we), 0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h005);
        step();
        disp_req = 0;
        @(negedge clk100);
        chk("rd_valid", 32'(disp_valid), 1);
        chk("rd_data", 32'(disp_data), 32'h41);
        step();
        @(negedge clk100);
        chk("rd_valid_once", 32'(disp_valid), 0);
        step();

        // both writers continuously: alternate starting with writer 0
        wr0_req = 1; wr0_addr = 12'd10; wr0_data = 8'hAA;
        wr1_req = 1; wr1_addr = 12'd11; wr1_data = 8'hBB;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk100);
            chk("rr_ack0", 32'(wr0_ack), (k % 2 == 0) ? 1 : 0);
            chk("rr_ack1", 32'(wr1_ack), (k % 2 == 1) ? 1 : 0);
            chk("rr_we", 32'(ram_we), 1);
            chk("rr_addr", 32'(ram_addr), (k % 2 == 0) ? 10 : 11);
            step();
        end
        wr0_req = 0; wr1_req = 0;
        step();
        chk("rr_mem10", 32'(mem[10]), 32'hAA);
        chk("rr_mem11", 32'(mem[11]), 32'hBB);

        // writer 0 blocked by 3 display cycles, served on the 4th
        wr0_req = 1; wr0_addr = 12'd20; wr0_data = 8'hCC;
        for (int k = 0; k < 3; k++) begin
            disp_req = 1; disp_addr = 12'(k);
            @(negedge clk100);
            chk("blk_ack0", 32'(wr0_ack), 0);
            chk("blk_we", 32'(ram_we), 0);
            step();
        end
        disp_req = 0;
        @(negedge clk100);
        chk("blk_ack0_4th", 32'(wr0_ack), 1);
        chk("blk_we_4th", 32'(ram_we), 1);
        chk("blk_addr_4th", 32'(ram_addr), 20);
        step();
        wr0_req = 0;
        step();
        chk("blk_mem20", 32'(mem[20]), 32'hCC);

        // out-of-range writer 1: acked, RAM untouched
        wr1_req = 1; wr1_addr = 12'd2400; wr1_data = 8'h77;
        @(negedge clk100);
        chk("oor_ack1", 32'(wr1_ack), 1);
        chk("oor_ram_en", 32'(ram_en), 0);
        step();
        wr1_req = 0;
        step();
        chk("oor_mem2400", 32'(mem[2400]), 32'(pat(2400)));

        // clear with display every 4th cycle; writer 0 served alongside clear_start
        pre_go = 1;
        step();
        pre_go = 0;
        clear_start = 1; wr0_req = 1; wr0_addr = 12'd2600; wr0_data = 8'h11;
        @(negedge clk100);
        chk("clr_start_ack0", 32'(wr0_ack), 1);
        chk("clr_start_busy", 32'(busy), 0);
        step();
        clear_start = 0; wr0_req = 0;
        wr1_req = 1; wr1_addr = 12'd2500; wr1_data = 8'h22;
        busy_cycles = 0; skipped = 0; wr1_busy_acks = 0; done = 0;
        for (int c = 0; c < 5000; c++) begin
            disp_req = (c % 4 == 3); disp_addr = 12'(c);
            clear_start = (c == 100);
            @(negedge clk100);
            if (!busy) begin done = 1; break; end
            busy_cycles++;
            if (disp_req) skipped++;
            if (wr1_ack) wr1_busy_acks++;
            step();
        end
        chk("clr_done", 32'(done), 1);
        chk("clr_busy_cycles", 32'(busy_cycles), 3199);
        chk("clr_busy_vs_skip", 32'(busy_cycles), 32'(2400 + skipped));
        chk("clr_no_wr_ack", 32'(wr1_busy_acks), 0);
        step();
        disp_req = 0; clear_start = 0;
        @(negedge clk100);
        chk("clr_after_ack1", 32'(wr1_ack), 1);
        step();
        wr1_req = 0;
        step();
        bad = 0;
        for (int a = 0; a < 2400; a++) if (mem[a] !== 8'h20 || wcount[a] != 1) bad++;
        chk("clr_fill_once", 32'(bad), 0);
        chk("clr_mem2400", 32'(mem[2400]), 32'(pat(2400)));

        // reset when the clear counter reaches 1000
        pre_go = 1;
        step();
        pre_go = 0; clear_start = 1;
        step();
        clear_start = 0;
        repeat (1000) step();
        reset = 1;
        @(negedge clk100);
        chk("rst_mid_we", 32'(ram_we), 0);
        step();
        reset = 0;
        @(negedge clk100);
        chk("rst_mid_busy", 32'(busy), 0);
`ifdef TEXTARB_STATS_EN
        chk("rst_mid_stall", 32'(stall_cnt), 0);
`endif
        repeat (4) step();
        bad = 0;
        for (int a = 0; a < 1000; a++) if (mem[a] !== 8'h20) bad++;
        chk("rst_mid_low_fill", 32'(bad), 0);
        bad = 0;
        for (int a = 1000; a < 2400; a++) if (mem[a] !== pat(a)) bad++;
        chk("rst_mid_high_keep", 32'(bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
